// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable counter.
//   state_e      : FSM state encoding (IDLE / RUN / HALT)
//   MODE_*       : 2-bit terminal-step behaviour selectors
//   mode_halts() : true when a terminal step in the given mode parks the FSM in HALT
package prog_counter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  // 2'b11 is reserved and decodes as wrap.

  function automatic logic mode_halts(input logic [1:0] mode);
    return (mode == MODE_SAT) || (mode == MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/prog_counter_next.sv
// Combinational next-count datapath for prog_counter.
//   count_i       : current counter value
//   limit_i       : up-count terminal value / down-count wrap value
//   dir_i         : 0 = up, 1 = down
//   mode_i        : terminal-step behaviour (wrap / saturate / one-shot / reserved=wrap)
//   reload_i      : value restored on a one-shot terminal step
//   count_next_o  : counter value after a step
//   terminal_o    : this step is a terminal step
module prog_counter_next
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] reload_i,
  output logic [WIDTH-1:0] count_next_o,
  output logic             terminal_o
);

  logic [WIDTH-1:0] wrap_val;

  // Terminal checks guarantee +1 / -1 never cross the 2^WIDTH boundary.
  assign terminal_o = dir_i ? (count_i == '0) : (count_i >= limit_i);
  assign wrap_val   = dir_i ? limit_i : '0;

  always_comb begin
    count_next_o = count_i;
    if (!terminal_o) begin
      count_next_o = dir_i ? (count_i - WIDTH'(1)) : (count_i + WIDTH'(1));
    end else begin
      unique case (mode_i)
        MODE_SAT:     count_next_o = count_i;
        MODE_ONESHOT: count_next_o = reload_i;
        default:      count_next_o = wrap_val;
      endcase
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with IDLE/RUN/HALT control FSM.
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   en       : count enable (steps only in RUN)
//   start    : level, IDLE -> RUN
//   stop     : level, RUN/HALT -> IDLE, count held
//   load     : synchronous load of count and reload register from load_val
//   load_val : load value
//   limit    : up terminal value / down wrap value
//   dir      : 0 = up, 1 = down
//   mode     : 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   count    : registered counter value
//   tc       : one-cycle pulse the cycle after a terminal step
//   busy     : state == RUN
//   done     : state == HALT
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;

  logic [WIDTH-1:0] count_d;
  logic             terminal;

  prog_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count_i      (count_q),
    .limit_i      (limit),
    .dir_i        (dir),
    .mode_i       (mode),
    .reload_i     (reload_q),
    .count_next_o (count_d),
    .terminal_o   (terminal)
  );

  // Priority: rst > load > stop > start > step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        count_q  <= load_val;
        reload_q <= load_val;
        if (state_q == StHalt) state_q <= StIdle;
      end else if (stop) begin
        state_q <= StIdle;
      end else if (start && (state_q == StIdle)) begin
        state_q <= StRun;
      end else if ((state_q == StRun) && en) begin
        count_q <= count_d;
        tc_q    <= terminal;
        if (terminal && mode_halts(mode)) state_q <= StHalt;
      end
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StHalt);

endmodule

// File: tb/tb_prog_counter.sv
// Directed, table-driven bench for prog_counter (WIDTH = 8).
module tb_prog_counter;
  import prog_counter_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, en, start, stop, load, dir, tc, busy, done;
  logic [W-1:0] load_val, limit, count;
  logic [1:0]   mode;

  prog_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .dir      (dir),
    .mode     (mode),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, en, start, stop, load;
    logic [W-1:0] lv, lim;
    logic         dir;
    logic [1:0]   mode;
    logic [W-1:0] e_cnt;
    logic         e_tc, e_busy, e_done;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t v(logic r, logic e, logic st, logic sp, logic ld, int lv, int lim,
                             logic d, logic [1:0] m, int c, logic t, logic b, logic dn);
    vec_t x;
    x.rst = r; x.en = e; x.start = st; x.stop = sp; x.load = ld;
    x.lv = W'(lv); x.lim = W'(lim); x.dir = d; x.mode = m;
    x.e_cnt = W'(c); x.e_tc = t; x.e_busy = b; x.e_done = dn;
    return x;
  endfunction

  // Drive one cycle of inputs, clock it, and check outputs 1 time unit after the edge.
  task automatic apply(input vec_t x, input string name);
    rst = x.rst; en = x.en; start = x.start; stop = x.stop; load = x.load;
    load_val = x.lv; limit = x.lim; dir = x.dir; mode = x.mode;
    @(posedge clk);
    #1;
    n_vec++;
    if (count !== x.e_cnt || tc !== x.e_tc || busy !== x.e_busy || done !== x.e_done) begin
      n_fail++;
      $display("FAIL %s: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
               name, count, tc, busy, done, x.e_cnt, x.e_tc, x.e_busy, x.e_done);
    end
  endtask

  localparam logic [1:0] WR = MODE_WRAP, SA = MODE_SAT, OS = MODE_ONESHOT, RS = 2'b11;

  initial begin
    // rst en st sp ld lv lim dir mode | cnt tc busy done
    // Reset with other inputs active.
    tbl.push_back(v(1,1,1,0,0,  0,  0,0,WR,   0,0,0,0));
    // Up wrap through limit 252.
    tbl.push_back(v(0,0,0,0,1,250,252,0,WR, 250,0,0,0));
    tbl.push_back(v(0,1,1,0,0,  0,252,0,WR, 250,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,252,0,WR, 251,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,252,0,WR, 252,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,252,0,WR,   0,1,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,252,0,WR,   1,0,1,0));
    // Load beats a would-be terminal step at count == limit == 10.
    tbl.push_back(v(0,1,0,0,1, 10, 10,0,WR,  10,0,1,0));
    tbl.push_back(v(0,1,0,0,1,  7, 10,0,WR,   7,0,1,0));
    // Limit lowered below count makes the next up step terminal.
    tbl.push_back(v(0,1,0,0,1,200,255,0,WR, 200,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0, 50,0,WR,   0,1,1,0));
    tbl.push_back(v(0,1,0,0,0,  0, 50,0,WR,   1,0,1,0));
    // Reset mid-run with start/en high.
    tbl.push_back(v(0,1,0,0,1,100, 50,0,WR, 100,0,1,0));
    tbl.push_back(v(1,1,1,0,0,  0, 50,0,WR,   0,0,0,0));
    // Reset on a terminal-step edge discards the tc.
    tbl.push_back(v(0,1,1,0,0,  0, 50,0,WR,   0,0,1,0));
    tbl.push_back(v(0,1,0,0,1, 50, 50,0,WR,  50,0,1,0));
    tbl.push_back(v(1,1,0,0,0,  0, 50,0,WR,   0,0,0,0));
    // One-shot down from 3.
    tbl.push_back(v(0,0,0,0,1,  3,  0,1,OS,   3,0,0,0));
    tbl.push_back(v(0,1,1,0,0,  0,  0,1,OS,   3,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  0,1,OS,   2,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  0,1,OS,   1,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  0,1,OS,   0,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  0,1,OS,   3,1,0,1));
    tbl.push_back(v(0,1,0,0,0,  0,  0,1,OS,   3,0,0,1));
    tbl.push_back(v(0,1,1,0,0,  0,  0,1,OS,   3,0,0,1));
    tbl.push_back(v(0,1,0,1,0,  0,  0,1,OS,   3,0,0,0));
    // Saturate up to 5.
    tbl.push_back(v(1,0,0,0,0,  0,  5,0,SA,   0,0,0,0));
    tbl.push_back(v(0,1,1,0,0,  0,  5,0,SA,   0,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  5,0,SA,   1,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  5,0,SA,   2,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  5,0,SA,   3,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  5,0,SA,   4,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  5,0,SA,   5,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  5,0,SA,   5,1,0,1));
    tbl.push_back(v(0,1,0,0,0,  0,  5,0,SA,   5,0,0,1));
    tbl.push_back(v(0,1,0,1,0,  0,  5,0,SA,   5,0,0,0));
    // Load in HALT returns to IDLE.
    tbl.push_back(v(0,1,1,0,0,  0,  5,0,SA,   5,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  5,0,SA,   5,1,0,1));
    tbl.push_back(v(0,1,0,0,1,  9,  5,0,SA,   9,0,0,0));
    // Down wrap to limit.
    tbl.push_back(v(0,1,1,0,0,  0,  4,1,WR,   9,0,1,0));
    tbl.push_back(v(0,1,0,0,1,  1,  4,1,WR,   1,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  4,1,WR,   0,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  4,1,WR,   4,1,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,  4,1,WR,   3,0,1,0));
    // Reserved mode acts as wrap at full-scale limit.
    tbl.push_back(v(0,1,0,0,1,254,255,0,RS, 254,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,255,0,RS, 255,0,1,0));
    tbl.push_back(v(0,1,0,0,0,  0,255,0,RS,   0,1,1,0));
    // stop beats start; en alone does nothing in IDLE; en=0 holds in RUN.
    tbl.push_back(v(0,1,1,1,0,  0,255,0,WR,   0,0,0,0));
    tbl.push_back(v(0,1,0,0,0,  0,255,0,WR,   0,0,0,0));
    tbl.push_back(v(0,0,1,0,0,  0,255,0,WR,   0,0,1,0));
    tbl.push_back(v(0,0,0,0,0,  0,255,0,WR,   0,0,1,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // limit = 0, up wrap: every enabled step is terminal, count stays 0.
    for (int i = 0; i < 4; i++) apply(v(0,1,0,0,0,0,0,0,WR, 0,1,1,0), $sformatf("lim0_%0d", i));
    apply(v(0,0,0,0,0,0,0,0,WR, 0,0,1,0), "lim0_hold");

    // Direction switch mid-run takes effect on the very next step.
    apply(v(0,1,0,0,1,20,100,0,WR, 20,0,1,0), "dir_load");
    apply(v(0,1,0,0,0, 0,100,0,WR, 21,0,1,0), "dir_up");
    apply(v(0,1,0,0,0, 0,100,1,WR, 20,0,1,0), "dir_down");
    // Mode switch to saturate then terminal down step halts with count held.
    apply(v(0,1,0,0,1, 0,100,1,SA,  0,0,1,0), "sat_down_ld");
    apply(v(0,1,0,0,0, 0,100,1,SA,  0,1,0,1), "sat_down_tc");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter, load and limit width (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit, count enable; a step occurs only in RUN with en=1.
REQ-005 The block SHALL have port start, input, 1 bit, a level sampled each cycle that starts counting.
REQ-006 The block SHALL have port stop, input, 1 bit, a level sampled each cycle that stops counting.
REQ-007 The block SHALL have port load, input, 1 bit, the synchronous load strobe.
REQ-008 The block SHALL have port load_val, input, WIDTH bits, the load value, also captured into the reload register.
REQ-009 The block SHALL have port limit, input, WIDTH bits, the up-count terminal value and the down-count wrap value.
REQ-010 The block SHALL have port dir, input, 1 bit: 0=up, 1=down.
REQ-011 The block SHALL have port mode, input, 2 bits: 00=wrap, 01=saturate, 10=one-shot, 11=reserved (behaves as wrap).
REQ-012 The block SHALL have port count, output, WIDTH bits, the registered counter value.
REQ-013 The block SHALL have port tc, output, 1 bit, a registered one-cycle terminal-count pulse.
REQ-014 The block SHALL have port busy, output, 1 bit, high iff state==RUN.
REQ-015 The block SHALL have port done, output, 1 bit, high iff state==HALT.

Function
REQ-016 The block SHALL implement states IDLE, RUN and HALT.
REQ-017 Per-cycle priority SHALL be rst > load > stop > start > step.
REQ-018 On load, count and the reload register SHALL take load_val next cycle; IDLE and RUN are kept; HALT goes to IDLE; no step and no tc that cycle.
REQ-019 stop SHALL move RUN or HALT to IDLE with count held.
REQ-020 start SHALL move IDLE to RUN; start in RUN or HALT SHALL be ignored.
REQ-021 A terminal step SHALL be a step with (dir=0 and count>=limit) or (dir=1 and count==0); other steps SHALL be count+1 (up) or count-1 (down).
REQ-022 On a terminal step in wrap mode, count SHALL become 0 (up) or limit (down), and the state SHALL stay RUN.
REQ-023 On a terminal step in saturate mode, count SHALL hold, and the state SHALL become HALT.
REQ-024 On a terminal step in one-shot mode, count SHALL become the reload register, and the state SHALL become HALT.
REQ-025 tc SHALL be 1 for exactly the cycle after each terminal step and 0 otherwise.
REQ-026 With limit=0 in up wrap mode, every step SHALL be terminal: count stays 0 and tc is high every enabled cycle.
REQ-027 Changes to dir, mode or limit SHALL take effect on the next step with no pipeline delay; a limit lowered below count SHALL make the next up step terminal.
REQ-028 Arithmetic SHALL be WIDTH bits, and no step SHALL pass through the 2^WIDTH modulo except via REQ-022.

Reset
REQ-029 While rst=1 at a clock edge, the next cycle SHALL have count=0, reload register=0, state=IDLE and tc=busy=done=0, regardless of other inputs.
REQ-030 Reset mid-run SHALL discard any pending tc.

Structure
REQ-031 Package prog_counter_pkg SHALL hold the state enum (IDLE/RUN/HALT) and the mode constants (MODE_WRAP, MODE_SAT, MODE_ONESHOT).
REQ-032 One combinational sub-module, prog_counter_next, SHALL compute the next count and the terminal flag from count, limit, dir, mode and reload; the top SHALL hold the FSM and registers.

Verification (WIDTH=8)
REQ-033 Load 250, limit=252, wrap, up, start, en=1 -> count 250,251,252,0,1; tc high only the cycle count shows 0.
REQ-034 Load 3, dir=1, one-shot, start -> count 3,2,1,0,3; done=1, busy=0 from the cycle count returns to 3; one tc pulse; a later start is ignored.
REQ-035 From 0, limit=5, saturate, up -> count reaches 5 and holds; done=1; stop -> IDLE with done=0 and count=5.
REQ-036 count=limit=10, wrap, load=1 with load_val=7 in the same cycle -> count=7, tc=0, state RUN.
REQ-037 Running up at count=200, limit changed to 50 -> next count 0 with tc pulse.
REQ-038 rst with start=en=1 at count=100 -> count=0, IDLE, tc=busy=done=0 the next cycle.
